// File: rtl/axi4lite_pkg.sv
// rtl/axi4lite_pkg.sv - shared AXI4-Lite widths, response codes and engine state types
//
// Purpose : common definitions for the AXI4-Lite memory slice.
// Contents: bus widths, response encodings OKAY/EXOKAY/SLVERR/DECERR,
//           write engine states (wstate_t) and read engine states (rstate_t).
package axi4lite_pkg;

    localparam int AXI4_ADDR_BITS = 32;
    localparam int AXI4_DATA_BITS = 64;
    localparam int AXI4_STRB_BITS = AXI4_DATA_BITS / 8;
    localparam int AXI4_PROT_BITS = 3;
    localparam int AXI4_RESP_BITS = 2;

    localparam logic [AXI4_RESP_BITS-1:0] OKAY   = 2'b00;
    localparam logic [AXI4_RESP_BITS-1:0] EXOKAY = 2'b01;
    localparam logic [AXI4_RESP_BITS-1:0] SLVERR = 2'b10;
    localparam logic [AXI4_RESP_BITS-1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_WRITE = 2'd1,
        W_RESP  = 2'd2
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_READ = 2'd1,
        R_RESP = 2'd2
    } rstate_t;

endpackage

// File: rtl/axi4lite_mem_array.sv
// rtl/axi4lite_mem_array.sv - DEPTH x AXI4_DATA_BITS storage, byte-enabled write, registered read
//
// Purpose : backing store for axi4lite_mem. Contents and read register are
//           deliberately not reset so the array maps onto block RAM.
// Ports   : clk                 clock
//           we/waddr/wdata/wstrb write port, byte lane i written iff wstrb[i]
//           re/raddr            read enable and word index
//           rdata               registered read data (updated only when re)
// A read and write to the same word on the same edge returns the old word.
module axi4lite_mem_array
    import axi4lite_pkg::*;
#(
    parameter int DEPTH    = 1024,
    parameter int IDX_BITS = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [IDX_BITS-1:0]       waddr,
    input  logic [AXI4_DATA_BITS-1:0] wdata,
    input  logic [AXI4_STRB_BITS-1:0] wstrb,
    input  logic                      re,
    input  logic [IDX_BITS-1:0]       raddr,
    output logic [AXI4_DATA_BITS-1:0] rdata
);

    logic [AXI4_DATA_BITS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < AXI4_STRB_BITS; i++) begin
                if (wstrb[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axi4lite_mem.sv
// rtl/axi4lite_mem.sv - byte-addressable AXI4-Lite slave memory with independent write/read engines
//
// Purpose : AXI4-Lite backing store. Write engine W_IDLE->W_WRITE->W_RESP,
//           read engine R_IDLE->R_READ->R_RESP, running concurrently.
// Config  : define AXI4LITE_MEM_DECERR_EN to answer offsets >= DEPTH*AXI4_STRB_BITS
//           with DECERR (writes dropped, read data 0); otherwise the word
//           index wraps modulo DEPTH and every response is OKAY.
// Ports   : clk, rstn (asynchronous, active low)
//           s_axi4lite_aw_*  write address  (ready out; valid, addr, prot in)
//           s_axi4lite_w_*   write data     (ready out; valid, data, strb in)
//           s_axi4lite_b_*   write response (ready in; valid, resp out)
//           s_axi4lite_ar_*  read address   (ready out; valid, addr, prot in)
//           s_axi4lite_r_*   read data      (ready in; valid, data, resp out)
module axi4lite_mem
    import axi4lite_pkg::*;
#(
    parameter int                        DEPTH     = 1024,
    parameter logic [AXI4_ADDR_BITS-1:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic                      clk,
    input  logic                      rstn,

    output logic                      s_axi4lite_aw_ready,
    input  logic                      s_axi4lite_aw_valid,
    input  logic [AXI4_ADDR_BITS-1:0] s_axi4lite_aw_addr,
    input  logic [AXI4_PROT_BITS-1:0] s_axi4lite_aw_prot,

    output logic                      s_axi4lite_w_ready,
    input  logic                      s_axi4lite_w_valid,
    input  logic [AXI4_DATA_BITS-1:0] s_axi4lite_w_data,
    input  logic [AXI4_STRB_BITS-1:0] s_axi4lite_w_strb,

    input  logic                      s_axi4lite_b_ready,
    output logic                      s_axi4lite_b_valid,
    output logic [AXI4_RESP_BITS-1:0] s_axi4lite_b_resp,

    output logic                      s_axi4lite_ar_ready,
    input  logic                      s_axi4lite_ar_valid,
    input  logic [AXI4_ADDR_BITS-1:0] s_axi4lite_ar_addr,
    input  logic [AXI4_PROT_BITS-1:0] s_axi4lite_ar_prot,

    input  logic                      s_axi4lite_r_ready,
    output logic                      s_axi4lite_r_valid,
    output logic [AXI4_DATA_BITS-1:0] s_axi4lite_r_data,
    output logic [AXI4_RESP_BITS-1:0] s_axi4lite_r_resp
);

    localparam int IDX_BITS  = $clog2(DEPTH);
    localparam int LANE_BITS = $clog2(AXI4_STRB_BITS);

    // ------------------------------------------------------------------
    // Address decode: byte offset from the base, lane bits dropped.
    // ------------------------------------------------------------------
    logic [AXI4_ADDR_BITS-1:0] aw_off, ar_off;
    logic [IDX_BITS-1:0]       aw_idx, ar_idx;
    logic                      aw_oob, ar_oob;

    assign aw_off = s_axi4lite_aw_addr - BASE_ADDR;
    assign ar_off = s_axi4lite_ar_addr - BASE_ADDR;
    assign aw_idx = aw_off[LANE_BITS +: IDX_BITS];
    assign ar_idx = ar_off[LANE_BITS +: IDX_BITS];

`ifdef AXI4LITE_MEM_DECERR_EN
    assign aw_oob = (aw_off >> (LANE_BITS + IDX_BITS)) != '0;
    assign ar_oob = (ar_off >> (LANE_BITS + IDX_BITS)) != '0;
`else
    assign aw_oob = 1'b0;
    assign ar_oob = 1'b0;
`endif

    // prot and the lane/upper offset bits carry no meaning for this memory.
    logic unused;
    assign unused = ^{s_axi4lite_aw_prot, s_axi4lite_ar_prot, aw_off, ar_off};

    // ------------------------------------------------------------------
    // Write engine
    // ------------------------------------------------------------------
    wstate_t                   wstate, wnext;
    logic                      aw_held, w_held;
    logic                      aw_open, w_open;
    logic [IDX_BITS-1:0]       w_idx_q;
    logic                      w_oob_q;
    logic [AXI4_DATA_BITS-1:0] w_data_q;
    logic [AXI4_STRB_BITS-1:0] w_strb_q;
    logic                      mem_we;
    logic                      b_valid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wstate <= W_IDLE;
        end else begin
            wstate <= wnext;
        end
    end

    always_comb begin
        wnext   = wstate;
        aw_open = 1'b0;
        w_open  = 1'b0;
        mem_we  = 1'b0;
        b_valid = 1'b0;
        unique case (wstate)
            W_IDLE: begin
                aw_open = !aw_held;
                w_open  = !w_held;
                // Leave as soon as both beats are held, counting beats
                // captured on this very edge.
                if ((aw_held || (aw_open && s_axi4lite_aw_valid)) &&
                    (w_held  || (w_open  && s_axi4lite_w_valid))) begin
                    wnext = W_WRITE;
                end
            end
            W_WRITE: begin
                mem_we = !w_oob_q;
                wnext  = W_RESP;
            end
            W_RESP: begin
                b_valid = 1'b1;
                if (s_axi4lite_b_ready) begin
                    wnext = W_IDLE;
                end
            end
            default: wnext = W_IDLE;
        endcase
    end

    // AW and W holding registers, filled independently while idle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            w_idx_q  <= '0;
            w_oob_q  <= 1'b0;
            w_data_q <= '0;
            w_strb_q <= '0;
        end else begin
            if (aw_open && s_axi4lite_aw_valid) begin
                aw_held <= 1'b1;
                w_idx_q <= aw_idx;
                w_oob_q <= aw_oob;
            end
            if (w_open && s_axi4lite_w_valid) begin
                w_held   <= 1'b1;
                w_data_q <= s_axi4lite_w_data;
                w_strb_q <= s_axi4lite_w_strb;
            end
            if (wstate == W_RESP && s_axi4lite_b_ready) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    // Readies are forced low while reset is asserted, not just after it.
    assign s_axi4lite_aw_ready = rstn & aw_open;
    assign s_axi4lite_w_ready  = rstn & w_open;
    assign s_axi4lite_b_valid  = b_valid;
    assign s_axi4lite_b_resp   = (b_valid && w_oob_q) ? DECERR : OKAY;

    // ------------------------------------------------------------------
    // Read engine
    // ------------------------------------------------------------------
    rstate_t                   rstate, rnext;
    logic                      ar_open;
    logic                      mem_re;
    logic                      r_valid;
    logic [IDX_BITS-1:0]       r_idx_q;
    logic                      r_oob_q;
    logic [AXI4_DATA_BITS-1:0] arr_rdata;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rstate <= R_IDLE;
        end else begin
            rstate <= rnext;
        end
    end

    always_comb begin
        rnext   = rstate;
        ar_open = 1'b0;
        mem_re  = 1'b0;
        r_valid = 1'b0;
        unique case (rstate)
            R_IDLE: begin
                ar_open = 1'b1;
                if (s_axi4lite_ar_valid) begin
                    rnext = R_READ;
                end
            end
            R_READ: begin
                mem_re = 1'b1;
                rnext  = R_RESP;
            end
            R_RESP: begin
                r_valid = 1'b1;
                if (s_axi4lite_r_ready) begin
                    rnext = R_IDLE;
                end
            end
            default: rnext = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_idx_q <= '0;
            r_oob_q <= 1'b0;
        end else if (ar_open && s_axi4lite_ar_valid) begin
            r_idx_q <= ar_idx;
            r_oob_q <= ar_oob;
        end
    end

    assign s_axi4lite_ar_ready = rstn & ar_open;
    assign s_axi4lite_r_valid  = r_valid;
    // The array read register has no reset; mask it so r_data is 0 outside
    // R_RESP and for out-of-range reads. It only changes in R_READ, so the
    // value is stable for the whole of R_RESP.
    assign s_axi4lite_r_data   = (r_valid && !r_oob_q) ? arr_rdata : '0;
    assign s_axi4lite_r_resp   = (r_valid && r_oob_q) ? DECERR : OKAY;

    axi4lite_mem_array #(
        .DEPTH    (DEPTH),
        .IDX_BITS (IDX_BITS)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (w_idx_q),
        .wdata (w_data_q),
        .wstrb (w_strb_q),
        .re    (mem_re),
        .raddr (r_idx_q),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_axi4lite_mem.sv
// tb/tb_axi4lite_mem.sv - scoreboard bench for axi4lite_mem against a byte-array reference model
module tb_axi4lite_mem;
    import axi4lite_pkg::*;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
    } rexp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        aw_ready, aw_valid = 1'b0;
    logic [31:0] aw_addr = '0;
    logic [2:0]  aw_prot = '0;
    logic        w_ready, w_valid = 1'b0;
    logic [63:0] w_data = '0;
    logic [7:0]  w_strb = '0;
    logic        b_ready = 1'b0, b_valid;
    logic [1:0]  b_resp;
    logic        ar_ready, ar_valid = 1'b0;
    logic [31:0] ar_addr = '0;
    logic [2:0]  ar_prot = '0;
    logic        r_ready = 1'b0, r_valid;
    logic [63:0] r_data;
    logic [1:0]  r_resp;

    int n_checks = 0;
    int n_errors = 0;
    int bmode = 1;   // 0: hold low, 1: hold high, 2: random
    int rmode = 1;

    logic [1:0]  bq [$];
    rexp_t       rq [$];
    logic [63:0] model_mem [DEPTH];

    always #5 clk = ~clk;

    axi4lite_mem #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .s_axi4lite_aw_ready (aw_ready),
        .s_axi4lite_aw_valid (aw_valid),
        .s_axi4lite_aw_addr  (aw_addr),
        .s_axi4lite_aw_prot  (aw_prot),
        .s_axi4lite_w_ready  (w_ready),
        .s_axi4lite_w_valid  (w_valid),
        .s_axi4lite_w_data   (w_data),
        .s_axi4lite_w_strb   (w_strb),
        .s_axi4lite_b_ready  (b_ready),
        .s_axi4lite_b_valid  (b_valid),
        .s_axi4lite_b_resp   (b_resp),
        .s_axi4lite_ar_ready (ar_ready),
        .s_axi4lite_ar_valid (ar_valid),
        .s_axi4lite_ar_addr  (ar_addr),
        .s_axi4lite_ar_prot  (ar_prot),
        .s_axi4lite_r_ready  (r_ready),
        .s_axi4lite_r_valid  (r_valid),
        .s_axi4lite_r_data   (r_data),
        .s_axi4lite_r_resp   (r_resp)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Reference model: byte offset from BASE, eight bytes per word.
    function automatic void decode(input logic [31:0] a, output int idx, output bit oob);
        logic [31:0] off;
        off = a - BASE;
        idx = int'((off / 8) % DEPTH);
`ifdef AXI4LITE_MEM_DECERR_EN
        oob = (off >= 32'(DEPTH * 8));
`else
        oob = 1'b0;
`endif
    endfunction

    function automatic logic [1:0] model_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        int idx;
        bit oob;
        decode(a, idx, oob);
        if (oob) return 2'b11;
        for (int i = 0; i < 8; i++) begin
            if (s[i]) model_mem[idx][8*i +: 8] = d[8*i +: 8];
        end
        return 2'b00;
    endfunction

    function automatic rexp_t model_read(input logic [31:0] a);
        int idx;
        bit oob;
        rexp_t e;
        decode(a, idx, oob);
        if (oob) begin
            e.data = '0;
            e.resp = 2'b11;
        end else begin
            e.data = model_mem[idx];
            e.resp = 2'b00;
        end
        return e;
    endfunction

    // Response ready drivers.
    initial begin : ready_drv
        forever begin
            @(posedge clk);
            #1;
            b_ready = (bmode == 2) ? 1'($urandom_range(0, 1)) : (bmode == 1);
            r_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1);
        end
    end

    // Monitor: pops expectations on every B/R handshake, checks valid hold.
    initial begin : monitor
        bit    b_pend, r_pend;
        logic [1:0] be;
        rexp_t re;
        b_pend = 1'b0;
        r_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                b_pend = 1'b0;
                r_pend = 1'b0;
            end else begin
                if (b_pend) check("b_valid_held", b_valid, 1);
                if (b_valid && b_ready) begin
                    if (bq.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL b_unexpected: got resp %h expected no response", b_resp);
                    end else begin
                        be = bq.pop_front();
                        check("b_resp", b_resp, be);
                    end
                    b_pend = 1'b0;
                end else begin
                    b_pend = b_valid;
                end

                if (r_pend) check("r_valid_held", r_valid, 1);
                if (r_valid && r_ready) begin
                    if (rq.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL r_unexpected: got data %h expected no response", r_data);
                    end else begin
                        re = rq.pop_front();
                        check("r_data", r_data, re.data);
                        check("r_resp", r_resp, re.resp);
                    end
                    r_pend = 1'b0;
                end else begin
                    r_pend = r_valid;
                end
            end
        end
    end

    // Beat tasks start at posedge+1 and return at posedge+1 after the handshake.
    task automatic aw_beat(input logic [31:0] a);
        bit ok = 1'b0;
        aw_addr = a; aw_prot = 3'($urandom); aw_valid = 1'b1;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (aw_ready) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("aw_handshake");
        @(posedge clk); #1;
        aw_valid = 1'b0;
    endtask

    task automatic w_beat(input logic [63:0] d, input logic [7:0] s);
        bit ok = 1'b0;
        w_data = d; w_strb = s; w_valid = 1'b1;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (w_ready) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("w_handshake");
        @(posedge clk); #1;
        w_valid = 1'b0;
    endtask

    task automatic ar_beat(input logic [31:0] a);
        bit ok = 1'b0;
        ar_addr = a; ar_prot = 3'($urandom); ar_valid = 1'b1;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (ar_ready) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("ar_handshake");
        @(posedge clk); #1;
        ar_valid = 1'b0;
    endtask

    // Counts sampling points after the handshake edge until valid is seen.
    task automatic wait_b(output int lat);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!b_valid && lat < 32);
    endtask

    task automatic wait_r(output int lat);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!r_valid && lat < 32);
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if (bq.size() == 0 && rq.size() == 0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) timeout("response_drain");
        @(posedge clk); #1;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        int lat;
        bq.push_back(model_write(a, d, s));
        fork
            aw_beat(a);
            w_beat(d, s);
        join
        wait_b(lat);
        check("b_latency", lat, 2);
        wait_drain();
    endtask

    task automatic axi_read(input logic [31:0] a);
        int lat;
        rq.push_back(model_read(a));
        ar_beat(a);
        wait_r(lat);
        check("r_latency", lat, 2);
        wait_drain();
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int lat;
        // Reset values
        #3;
        check("rst_aw_ready", aw_ready, 0);
        check("rst_w_ready",  w_ready,  0);
        check("rst_ar_ready", ar_ready, 0);
        check("rst_b_valid",  b_valid,  0);
        check("rst_r_valid",  r_valid,  0);
        check("rst_b_resp",   b_resp,   0);
        check("rst_r_resp",   r_resp,   0);
        check("rst_r_data",   r_data,   0);
        #19 rstn = 1'b1;
        #1;
        check("post_rst_aw_ready", aw_ready, 1);
        check("post_rst_w_ready",  w_ready,  1);
        check("post_rst_ar_ready", ar_ready, 1);
        @(posedge clk); #1;

        // Fill every word so later random reads have known contents.
        for (int i = 0; i < DEPTH; i++) begin
            axi_write(BASE + 32'(8 * i), {$urandom, $urandom}, 8'hFF);
        end

        // Full write / read, then strobed overwrite and an empty strobe.
        axi_write(BASE + 32'h8, 64'h1122_3344_5566_7788, 8'hFF);
        axi_read(BASE + 32'h8);
        axi_write(BASE + 32'h8, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
        axi_read(BASE + 32'h8);
        axi_write(BASE + 32'h8, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        axi_read(BASE + 32'hC);

        // W three cycles ahead of AW, then B held off for five cycles.
        bmode = 0;
        bq.push_back(model_write(BASE + 32'h20, 64'hDEAD_BEEF_0BAD_F00D, 8'hA5));
        check("w_ready_idle", w_ready, 1);
        w_beat(64'hDEAD_BEEF_0BAD_F00D, 8'hA5);
        repeat (3) begin
            @(negedge clk);
            check("aw_ready_while_w_held", aw_ready, 1);
            check("w_ready_after_w", w_ready, 0);
            check("b_valid_before_aw", b_valid, 0);
        end
        @(posedge clk); #1;
        aw_beat(BASE + 32'h20);
        wait_b(lat);
        check("b_latency_w_first", lat, 2);
        repeat (5) begin
            @(negedge clk);
            check("b_valid_backpressure", b_valid, 1);
            check("aw_ready_in_resp", aw_ready, 0);
        end
        bmode = 1;
        wait_drain();
        axi_read(BASE + 32'h20);

        // Write and read of the same word in the same cycle: read sees old data.
        axi_write(BASE + 32'h10, 64'h0, 8'hFF);
        rq.push_back(model_read(BASE + 32'h10));
        bq.push_back(model_write(BASE + 32'h10, 64'h5, 8'hFF));
        fork
            aw_beat(BASE + 32'h10);
            w_beat(64'h5, 8'hFF);
            ar_beat(BASE + 32'h10);
        join
        wait_drain();
        axi_read(BASE + 32'h10);

        // Just past the top of the array, and a misaligned address.
        axi_read(BASE + 32'(DEPTH * 8));
        axi_write(BASE + 32'(DEPTH * 8) + 32'h8, 64'h0123_4567_89AB_CDEF, 8'hFF);
        axi_read(BASE + 32'h8);
        axi_read(BASE + 32'h1B);

        // Randomized traffic with random backpressure.
        bmode = 2;
        rmode = 2;
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            int          pick;
            pick = $urandom_range(0, 9);
            if (pick == 0)      a = BASE - 32'(8 * $urandom_range(1, 4));
            else if (pick == 1) a = BASE + 32'(DEPTH * 8) + 32'(8 * $urandom_range(0, 15));
            else                a = BASE + 32'(8 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) axi_write(a, {$urandom, $urandom}, 8'($urandom));
            else                           axi_read(a);
        end
        bmode = 1;
        rmode = 1;

        // Reset while a read response is being held off.
        rmode = 0;
        @(posedge clk); #1;
        ar_beat(BASE + 32'h8);
        wait_r(lat);
        check("r_latency_pre_reset", lat, 2);
        @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        check("mid_rst_r_valid",  r_valid,  0);
        check("mid_rst_r_data",   r_data,   0);
        check("mid_rst_ar_ready", ar_ready, 0);
        check("mid_rst_w_ready",  w_ready,  0);
        rq.delete();
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        #1;
        check("post_rst2_ar_ready", ar_ready, 1);
        rmode = 1;
        @(posedge clk); #1;
        axi_read(BASE + 32'h8);
        axi_read(BASE + 32'h10);
        axi_read(BASE + 32'h20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
